// File: rtl/dcarb_pkg.sv
// Shared types and width constants for the D-cache port arbiter.
// dc_req_t is the latched request that drives the cache for one transaction.
package dcarb_pkg;

    localparam int DCARB_ADDR_WIDTH = 64;
    localparam int DCARB_DATA_WIDTH = 64;
    localparam int DCARB_LEN_WIDTH  = 2;

    // The page-table walker always sits on port 0.
    localparam int PORT_WALKER = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dcarb_state_t;

    typedef struct packed {
        logic [DCARB_ADDR_WIDTH-1:0] addr;
        logic                        write;
        logic [DCARB_DATA_WIDTH-1:0] wdata;
        logic [DCARB_LEN_WIDTH-1:0]  wlen;
        logic                        virt;
    } dc_req_t;

endpackage

// File: rtl/dcache_port_arbiter_rr_picker.sv
// Combinational round-robin picker: searches from last_grant+1 upward,
// wrapping, and returns the first requesting port as one-hot and index.
module rr_picker #(
    parameter  int NUM_PORTS = 3,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            int p;
            p = (int'(i_last) + i) % NUM_PORTS;
            if (!o_any && i_req[p]) begin
                o_any      = 1'b1;
                o_grant[p] = 1'b1;
                o_idx      = IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// N-port valid/ready arbiter in front of the D-cache; one transaction at a time.
// Optional build macro DCARB_PORT0_PRIORITY_EN: walker port 0 always wins in IDLE.
module dcache_port_arbiter #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = dcarb_pkg::DCARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = dcarb_pkg::DCARB_DATA_WIDTH,
    parameter int LEN_WIDTH  = dcarb_pkg::DCARB_LEN_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_PORTS*LEN_WIDTH-1:0]  req_wlen,
    input  logic [NUM_PORTS-1:0]            req_virtual,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [NUM_PORTS-1:0]            resp_write_done,
    output logic [DATA_WIDTH-1:0]           resp_rdata,
    output logic                            dc_en,
    output logic                            dc_write_en,
    output logic                            dc_virtual_en,
    output logic [ADDR_WIDTH-1:0]           dc_addr,
    output logic [DATA_WIDTH-1:0]           dc_wdata,
    output logic [LEN_WIDTH-1:0]            dc_wlen,
    input  logic [DATA_WIDTH-1:0]           dc_rdata,
    input  logic                            dc_rvalid,
    input  logic                            dc_write_done,
    output logic                            err_spurious,
    output logic                            dbg_busy
);
    import dcarb_pkg::*;

    // Handshake: a port is accepted on the rising edge where req_valid[i] and
    // req_ready[i] are both high; req_ready is one-hot, only in IDLE, never in reset.
    localparam int               IDX_W    = $clog2(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_PORTS - 1);

    dcarb_state_t         r_state, w_state_nxt;
    dc_req_t              r_req;
    logic [IDX_W-1:0]     r_owner, r_last_grant;
    logic                 r_err;

    logic [NUM_PORTS-1:0] w_rr_grant, w_grant;
    logic [IDX_W-1:0]     w_rr_idx, w_idx;
    logic                 w_rr_any, w_any, w_upd_last;
    logic                 w_accept, w_done, w_strobe;

    rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
        .i_req   (req_valid),
        .i_last  (r_last_grant),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

    always_comb begin
        w_grant    = w_rr_grant;
        w_idx      = w_rr_idx;
        w_any      = w_rr_any;
        w_upd_last = 1'b1;
`ifdef DCARB_PORT0_PRIORITY_EN
        // Walker grants leave the pointer alone so ports 1..N-1 keep their rotation.
        if (req_valid[PORT_WALKER]) begin
            w_grant              = '0;
            w_grant[PORT_WALKER] = 1'b1;
            w_idx                = IDX_W'(PORT_WALKER);
            w_any                = 1'b1;
            w_upd_last           = 1'b0;
        end
`endif
    end

    assign w_strobe = dc_rvalid | dc_write_done;
    assign w_done   = r_req.write ? dc_write_done : dc_rvalid;

    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        req_ready       = '0;
        resp_valid      = '0;
        resp_write_done = '0;
        resp_rdata      = '0;
        dc_en           = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any && reset) begin
                    req_ready   = w_grant;
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                dc_en = 1'b1;
                if (w_done) begin
                    resp_valid[r_owner]      = !r_req.write;
                    resp_write_done[r_owner] = r_req.write;
                    resp_rdata               = dc_rdata;
                    w_state_nxt              = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_req        <= '0;
            r_owner      <= '0;
            r_last_grant <= LAST_RST;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req.addr  <= req_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                r_req.write <= req_write[w_idx];
                r_req.wdata <= req_wdata[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
                r_req.wlen  <= req_wlen[int'(w_idx)*LEN_WIDTH +: LEN_WIDTH];
                r_req.virt  <= req_virtual[w_idx];
                r_owner     <= w_idx;
                if (w_upd_last) begin
                    r_last_grant <= w_idx;
                end
            end
            if (r_state == IDLE && w_strobe) begin
                r_err <= 1'b1;
            end
        end
    end

    assign dc_write_en   = dc_en & r_req.write;
    assign dc_virtual_en = dc_en & r_req.virt;
    assign dc_addr       = r_req.addr;
    assign dc_wdata      = r_req.wdata;
    assign dc_wlen       = r_req.wlen;
    assign err_spurious  = r_err;
    assign dbg_busy      = (r_state == BUSY);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter; expectations follow the build macro
// DCARB_PORT0_PRIORITY_EN where grant order depends on it.
module tb_dcache_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*LW-1:0] req_wlen = '0;
    logic [N-1:0]    req_virtual = '0;
    logic [N-1:0]    resp_valid, resp_write_done;
    logic [DW-1:0]   resp_rdata;
    logic            dc_en, dc_write_en, dc_virtual_en;
    logic [AW-1:0]   dc_addr;
    logic [DW-1:0]   dc_wdata;
    logic [LW-1:0]   dc_wlen;
    logic [DW-1:0]   dc_rdata = '0;
    logic            dc_rvalid = 1'b0;
    logic            dc_write_done = 1'b0;
    logic            err_spurious, dbg_busy;

    int n_total = 0;
    int n_bad   = 0;
    logic [N-1:0] exp_q[$];

    dcache_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wlen(req_wlen),
        .req_virtual(req_virtual),
        .resp_valid(resp_valid), .resp_write_done(resp_write_done), .resp_rdata(resp_rdata),
        .dc_en(dc_en), .dc_write_en(dc_write_en), .dc_virtual_en(dc_virtual_en),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wlen(dc_wlen),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_write_done(dc_write_done),
        .err_spurious(err_spurious), .dbg_busy(dbg_busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic set_port(input int p, input logic v, input logic [AW-1:0] a, input logic wr,
                            input logic [DW-1:0] wd, input logic [LW-1:0] wl, input logic vt);
        req_valid[p]             = v;
        req_addr[p*AW +: AW]     = a;
        req_write[p]             = wr;
        req_wdata[p*DW +: DW]    = wd;
        req_wlen[p*LW +: LW]     = wl;
        req_virtual[p]           = vt;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Returns just after the accept edge; idle counts dc_en-low cycles seen first.
    task automatic wait_grant(output logic [N-1:0] g, output int idle);
        bit found;
        g = '0;
        idle = 0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (!dc_en) idle++;
            if (req_ready != '0) begin
                g = req_ready;
                found = 1'b1;
            end
        end
        if (!found) $display("FAIL wait_grant: no req_ready within 20 cycles got=%b", req_ready);
        @(posedge clk); #1;
    endtask

    // Models a cache that strobes completion in the lat-th cycle of dc_en.
    task automatic serve(input int lat, input logic wr, input logic [DW-1:0] rd,
                         output logic [N-1:0] rv, output logic [N-1:0] rwd, output logic [DW-1:0] rdo,
                         output int en_cnt, output logic [AW-1:0] addr_seen, output logic virt_seen,
                         output logic [N-1:0] rdy_seen);
        en_cnt = 0; rv = '0; rwd = '0; rdo = '0; addr_seen = '0; virt_seen = 1'b0; rdy_seen = '0;
        for (int k = 1; k <= lat; k++) begin
            if (k == lat) begin
                if (wr) dc_write_done = 1'b1;
                else    dc_rvalid = 1'b1;
                dc_rdata = rd;
            end
            @(negedge clk);
            if (dc_en) en_cnt++;
            if (k == 1) begin
                addr_seen = dc_addr;
                virt_seen = dc_virtual_en;
                rdy_seen  = req_ready;
            end
            if (k == lat) begin
                rv  = resp_valid;
                rwd = resp_write_done;
                rdo = resp_rdata;
            end
            @(posedge clk); #1;
            dc_rvalid = 1'b0;
            dc_write_done = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        req_valid = 3'b111;
        dc_rvalid = 1'b1;
        dc_rdata  = 64'hFFFF_0000_1234_5678;
        #1;
        n_total++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL rst_req_ready got=%b exp=000", req_ready); end
        n_total++; if (dc_en !== 1'b0) begin n_bad++; $display("FAIL rst_dc_en got=%b exp=0", dc_en); end
        n_total++; if (resp_valid !== 3'b000) begin n_bad++; $display("FAIL rst_resp_valid got=%b exp=000", resp_valid); end
        n_total++; if (resp_rdata !== 64'h0) begin n_bad++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
        n_total++; if (dc_addr !== 64'h0) begin n_bad++; $display("FAIL rst_dc_addr got=%h exp=0", dc_addr); end
        n_total++; if (err_spurious !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", err_spurious); end
        n_total++; if (dbg_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", dbg_busy); end
        @(posedge clk); #1;
        reset = 1'b1;
        dc_rvalid = 1'b0;
        @(negedge clk);
        n_total++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL rst_first_grant got=%b exp=001", req_ready); end
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        logic [N-1:0] g, rv, rwd, rdy;
        logic [DW-1:0] rdo;
        logic [AW-1:0] a;
        logic vt;
        int idle, en;
        set_port(1, 1'b1, 64'h1000, 1'b0, '0, '0, 1'b1);
        wait_grant(g, idle);
        set_port(1, 1'b0, 64'h1000, 1'b0, '0, '0, 1'b1);
        serve(3, 1'b0, 64'hDEAD_BEEF, rv, rwd, rdo, en, a, vt, rdy);
        n_total++; if (g !== 3'b010) begin n_bad++; $display("FAIL rd_grant got=%b exp=010", g); end
        n_total++; if (rdy !== 3'b000) begin n_bad++; $display("FAIL rd_ready_busy got=%b exp=000", rdy); end
        n_total++; if (a !== 64'h1000) begin n_bad++; $display("FAIL rd_dc_addr got=%h exp=1000", a); end
        n_total++; if (en !== 3) begin n_bad++; $display("FAIL rd_dc_en_cycles got=%0d exp=3", en); end
        n_total++; if (rv !== 3'b010) begin n_bad++; $display("FAIL rd_resp_valid got=%b exp=010", rv); end
        n_total++; if (rwd !== 3'b000) begin n_bad++; $display("FAIL rd_resp_wdone got=%b exp=000", rwd); end
        n_total++; if (rdo !== 64'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", rdo); end
        @(negedge clk);
        n_total++; if (dc_en !== 1'b0) begin n_bad++; $display("FAIL rd_idle_dc_en got=%b exp=0", dc_en); end
        n_total++; if (resp_valid !== 3'b000) begin n_bad++; $display("FAIL rd_resp_after got=%b exp=000", resp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g, e, rv, rwd, rdy;
        logic [DW-1:0] rdo;
        logic [AW-1:0] a, ea;
        logic vt;
        int idle, en;
        apply_reset();
`ifdef DCARB_PORT0_PRIORITY_EN
        exp_q = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010};
`else
        exp_q = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 64'(32'h100 * (p + 1)), 1'b0, '0, '0, 1'b0);
        for (int t = 0; t < 6; t++) begin
            wait_grant(g, idle);
`ifdef DCARB_PORT0_PRIORITY_EN
            if (t == 2) req_valid[0] = 1'b0;
`endif
            serve(2, 1'b0, 64'(t), rv, rwd, rdo, en, a, vt, rdy);
            e = exp_q.pop_front();
            ea = '0;
            for (int p = 0; p < N; p++) if (e[p]) ea = 64'(32'h100 * (p + 1));
            n_total++; if (g !== e) begin n_bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", t, g, e); end
            n_total++; if (idle !== 1) begin n_bad++; $display("FAIL rr_idle_gap[%0d] got=%0d exp=1", t, idle); end
            n_total++; if (a !== ea) begin n_bad++; $display("FAIL rr_addr[%0d] got=%h exp=%h", t, a, ea); end
            n_total++; if (rv !== e) begin n_bad++; $display("FAIL rr_resp[%0d] got=%b exp=%b", t, rv, e); end
        end
        req_valid = '0;
    endtask

    task automatic test_write_stray();
        logic [N-1:0] g;
        int idle;
        set_port(2, 1'b1, 64'h2000, 1'b1, 64'h55AA, 2'd3, 1'b0);
        wait_grant(g, idle);
        set_port(2, 1'b0, 64'h2000, 1'b1, 64'h55AA, 2'd3, 1'b0);
        n_total++; if (g !== 3'b100) begin n_bad++; $display("FAIL wr_grant got=%b exp=100", g); end
        dc_rvalid = 1'b1;
        dc_rdata  = 64'h1234;
        @(negedge clk);
        n_total++; if (dc_write_en !== 1'b1) begin n_bad++; $display("FAIL wr_dc_write_en got=%b exp=1", dc_write_en); end
        n_total++; if (dc_wdata !== 64'h55AA) begin n_bad++; $display("FAIL wr_dc_wdata got=%h exp=55aa", dc_wdata); end
        n_total++; if (dc_wlen !== 2'd3) begin n_bad++; $display("FAIL wr_dc_wlen got=%0d exp=3", dc_wlen); end
        n_total++; if (resp_valid !== 3'b000) begin n_bad++; $display("FAIL wr_stray_resp got=%b exp=000", resp_valid); end
        n_total++; if (resp_write_done !== 3'b000) begin n_bad++; $display("FAIL wr_stray_wdone got=%b exp=000", resp_write_done); end
        @(posedge clk); #1;
        dc_rvalid = 1'b0;
        @(negedge clk);
        n_total++; if (dc_en !== 1'b1) begin n_bad++; $display("FAIL wr_still_busy got=%b exp=1", dc_en); end
        @(posedge clk); #1;
        dc_write_done = 1'b1;
        @(negedge clk);
        n_total++; if (resp_write_done !== 3'b100) begin n_bad++; $display("FAIL wr_wdone got=%b exp=100", resp_write_done); end
        n_total++; if (resp_valid !== 3'b000) begin n_bad++; $display("FAIL wr_resp_valid got=%b exp=000", resp_valid); end
        @(posedge clk); #1;
        dc_write_done = 1'b0;
        @(negedge clk);
        n_total++; if (dc_en !== 1'b0) begin n_bad++; $display("FAIL wr_idle got=%b exp=0", dc_en); end
        n_total++; if (err_spurious !== 1'b0) begin n_bad++; $display("FAIL wr_err got=%b exp=0", err_spurious); end
        @(posedge clk); #1;
    endtask

    task automatic test_virtual();
        logic [N-1:0] g, rv, rwd, rdy;
        logic [DW-1:0] rdo;
        logic [AW-1:0] a;
        logic vt;
        int idle, en;
        set_port(0, 1'b1, 64'h3000, 1'b0, '0, '0, 1'b0);
        set_port(1, 1'b1, 64'h3100, 1'b0, '0, '0, 1'b1);
        wait_grant(g, idle);
        req_valid[0] = 1'b0;
        serve(1, 1'b0, 64'hA0, rv, rwd, rdo, en, a, vt, rdy);
        n_total++; if (g !== 3'b001) begin n_bad++; $display("FAIL virt_grant0 got=%b exp=001", g); end
        n_total++; if (vt !== 1'b0) begin n_bad++; $display("FAIL virt_port0 got=%b exp=0", vt); end
        n_total++; if (a !== 64'h3000) begin n_bad++; $display("FAIL virt_addr0 got=%h exp=3000", a); end
        wait_grant(g, idle);
        req_valid[1] = 1'b0;
        serve(1, 1'b0, 64'hA1, rv, rwd, rdo, en, a, vt, rdy);
        n_total++; if (g !== 3'b010) begin n_bad++; $display("FAIL virt_grant1 got=%b exp=010", g); end
        n_total++; if (vt !== 1'b1) begin n_bad++; $display("FAIL virt_port1 got=%b exp=1", vt); end
        n_total++; if (rdo !== 64'hA1) begin n_bad++; $display("FAIL virt_rdata1 got=%h exp=a1", rdo); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g, rv, rwd, rdy;
        logic [DW-1:0] rdo;
        logic [AW-1:0] a;
        logic vt;
        int idle, en;
        set_port(1, 1'b1, 64'h4000, 1'b1, 64'h77, 2'd2, 1'b1);
        wait_grant(g, idle);
        set_port(1, 1'b0, 64'h4000, 1'b1, 64'h77, 2'd2, 1'b1);
        n_total++; if (g !== 3'b010) begin n_bad++; $display("FAIL mid_grant got=%b exp=010", g); end
        @(negedge clk);
        n_total++; if (dc_en !== 1'b1) begin n_bad++; $display("FAIL mid_busy got=%b exp=1", dc_en); end
        reset = 1'b0;
        req_valid[2] = 1'b1;
        #1;
        n_total++; if (dc_en !== 1'b0) begin n_bad++; $display("FAIL mid_dc_en got=%b exp=0", dc_en); end
        n_total++; if (dc_write_en !== 1'b0) begin n_bad++; $display("FAIL mid_dc_write_en got=%b exp=0", dc_write_en); end
        n_total++; if (dc_virtual_en !== 1'b0) begin n_bad++; $display("FAIL mid_dc_virt got=%b exp=0", dc_virtual_en); end
        n_total++; if (dc_addr !== 64'h0) begin n_bad++; $display("FAIL mid_dc_addr got=%h exp=0", dc_addr); end
        n_total++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL mid_req_ready got=%b exp=000", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        dc_rvalid = 1'b1;
        dc_rdata  = 64'hBAD;
        @(negedge clk);
        n_total++; if (resp_valid !== 3'b000) begin n_bad++; $display("FAIL mid_no_resp got=%b exp=000", resp_valid); end
        @(posedge clk); #1;
        dc_rvalid = 1'b0;
        @(negedge clk);
        n_total++; if (err_spurious !== 1'b1) begin n_bad++; $display("FAIL mid_err got=%b exp=1", err_spurious); end
        @(posedge clk); #1;
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 64'(32'h500 + p), 1'b0, '0, '0, 1'b0);
        wait_grant(g, idle);
        req_valid = '0;
        serve(1, 1'b0, 64'hC0, rv, rwd, rdo, en, a, vt, rdy);
        n_total++; if (g !== 3'b001) begin n_bad++; $display("FAIL mid_next_grant got=%b exp=001", g); end
        n_total++; if (rv !== 3'b001) begin n_bad++; $display("FAIL mid_next_resp got=%b exp=001", rv); end
        n_total++; if (err_spurious !== 1'b1) begin n_bad++; $display("FAIL mid_err_sticky got=%b exp=1", err_spurious); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_stray();
        test_virtual();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Parametrised N-port request arbiter in front of the D-cache, replacing the hard-wired two-way MMU/core mux in the memory system. Requesters (core load/store unit, MMU page-table walker, future prefetcher) each present a valid/ready request. One request is granted at a time, latched, and held on the D-cache inputs until the cache reports completion. The response is then steered back to the granted port only. Each request carries its own virtual-mode bit, so a walker port forces physical mode without an external override signal.

## Interface
- NUM_PORTS, 3, number of requester ports (2..8); port 0 is the walker port.
- ADDR_WIDTH, 64, request address width.
- DATA_WIDTH, 64, read/write data width.
- LEN_WIDTH, 2, width of log2(bytes) write length.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  NUM_PORTS  per-port request pending.
- req_ready  out  NUM_PORTS  one-hot accept strobe; reset 0.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at slice i.
- req_write  in  NUM_PORTS  1 = write, 0 = read.
- req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- req_wlen  in  NUM_PORTS*LEN_WIDTH  per-port write length.
- req_virtual  in  NUM_PORTS  per-port translate-enable.
- resp_valid  out  NUM_PORTS  one-hot read data valid; reset 0.
- resp_write_done  out  NUM_PORTS  one-hot write completion; reset 0.
- resp_rdata  out  DATA_WIDTH  read data, broadcast to all ports; reset 0.
- dc_en, dc_write_en, dc_virtual_en  out  1 each  cache controls; reset 0.
- dc_addr / dc_wdata / dc_wlen  out  ADDR_WIDTH / DATA_WIDTH / LEN_WIDTH  latched request fields; reset 0.
- dc_rdata  in  DATA_WIDTH  cache read data.
- dc_rvalid, dc_write_done  in  1 each  cache completion strobes.
- err_spurious  out  1  sticky flag: a completion strobe arrived while IDLE; reset 0.

## Operation
- The FSM has two states, IDLE and BUSY.
- IDLE behaviour:
  - dc_en = 0.
  - When any req_valid is high, the picker selects a winner w and req_ready[w] = 1 in the same cycle (combinational from req_valid and the pointer).
  - On that edge, port w's fields are latched into the request register, owner <= w, last_grant <= w, and the FSM moves to BUSY.
- BUSY behaviour:
  - dc_en = 1 and all dc_* outputs come from the request register; they are stable for the whole transaction.
  - req_ready = 0.
- Completion: a read completes on dc_rvalid and a write on dc_write_done while BUSY. In that cycle:
  - resp_valid[owner] or resp_write_done[owner] is driven combinationally from the strobe.
  - resp_rdata = dc_rdata.
  - The FSM returns to IDLE.
- Strobes of the wrong kind are ignored: dc_write_done during a read, dc_rvalid during a write.
- Round-robin: the search starts at port (last_grant+1) mod NUM_PORTS and wraps. last_grant resets to NUM_PORTS-1, so port 0 wins first after reset.
- Requesters must hold req_valid and their fields until they see req_ready. Deasserting early is legal; that request is simply not granted.
- A completion strobe arriving in IDLE sets err_spurious and produces no response. err_spurious clears only on reset.
- Reset asserted mid-transaction:
  - All outputs go to 0 immediately (asynchronous).
  - The in-flight request is dropped and no response is issued.
  - last_grant returns to NUM_PORTS-1.

## Timing
- Accept at edge T (req_valid[w] & req_ready[w]); dc_en first high in cycle T+1.
- The response is issued in the same cycle as the cache strobe, with zero added latency.
- dc_en is low for at least one IDLE cycle between transactions, so the cache always sees a fresh enable.
- Back-to-back throughput: with cache latency L (cycles from dc_en high to strobe), one request per L+1 cycles.
- Worst-case wait for a continuously requesting port without priority mode: NUM_PORTS-1 transactions.

## Configuration
- DCARB_PORT0_PRIORITY_EN defined:
  - Port 0 (walker) wins whenever req_valid[0] is high in IDLE, regardless of the pointer.
  - Granting port 0 does not update last_grant, so round-robin among ports 1..N-1 is preserved.
- Macro undefined: pure round-robin across all ports, port 0 included.

## Structure
- Package dcarb_pkg holds:
  - typedef dc_req_t, a struct {addr, write, wdata, wlen, virt} sized from the package width constants;
  - enum dcarb_state_t {IDLE, BUSY};
  - the PORT_WALKER = 0 constant.
- Sub-module rr_picker (combinational, parametrised on NUM_PORTS): inputs request vector and last_grant; outputs one-hot grant and its index. The priority override is applied in the parent under the macro.

## Test plan
- Single port 1 read of address 0x1000, cache strobes dc_rvalid after 3 cycles with rdata 0xDEADBEEF -> req_ready[1] for 1 cycle; dc_addr = 0x1000 with dc_en held 3 cycles; resp_valid = 3'b010 with resp_rdata = 0xDEADBEEF; other ports see no response.
- Ports 0, 1, 2 requesting continuously, priority macro off -> grant order 0, 1, 2, 0, 1, 2; dc_en low for exactly 1 cycle between transactions.
- Same stimulus with DCARB_PORT0_PRIORITY_EN defined -> order 0, 0, 0 while port 0 stays valid; after port 0 drops, order continues 1, 2, 1.
- Port 2 write (wlen = 3, wdata 0x55AA) followed by a stray dc_rvalid -> stray strobe ignored; dc_write_done yields resp_write_done = 3'b100; resp_valid stays 0.
- Port 0 request with req_virtual = 0 and port 1 with req_virtual = 1 -> dc_virtual_en is 0 during the port-0 transaction and 1 during port 1.
- reset pulled low in BUSY, then dc_rvalid pulsed after release -> no resp_valid; err_spurious = 1; the next grant goes to port 0.
